// File: rtl/sgd_scalar_bcast_tree.sv
// Scalar broadcast fan-out: queues signed scalars, applies an arithmetic right shift
// at the root, then copies value and lane mask down a registered binary tree to every bank lane.
module sgd_bcast_node #(
    parameter int MW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [31:0]   data_i,
    input  logic [MW-1:0] mask_i,
    output logic [31:0]   data_o,
    output logic [MW-1:0] mask_o
);
    logic [31:0]   data_q;
    logic [MW-1:0] mask_q;

    // Load only when the parent holds a live scalar; otherwise hold the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            mask_q <= '0;
        end else if (en_i) begin
            data_q <= data_i;
            mask_q <= mask_i;
        end
    end

    assign data_o = data_q;
    assign mask_o = mask_q;
endmodule

module sgd_scalar_bcast_tree #(
    parameter int TREE_DEPTH = 3,
    parameter int TREE_WIDTH = 1 << TREE_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [31:0]    s_input,
    input  logic [4:0]            s_shift,
    input  logic [TREE_WIDTH-1:0] s_lane_enable,
    input  logic                  s_input_valid,
    output logic                  s_input_ready,
    input  logic                  dispatch_en,
    output logic signed [31:0]    v_output [TREE_WIDTH-1:0],
    output logic                  v_output_enable [TREE_WIDTH-1:0],
    output logic                  v_output_valid,
    output logic [31:0]           dispatch_cnt
);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NODES = (1 << (TREE_DEPTH + 1)) - 1;
    localparam int LEAF0 = TREE_WIDTH - 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0]           data;
        logic [4:0]            shift;
        logic [TREE_WIDTH-1:0] mask;
    } entry_t;

    entry_t          mem_q [FIFO_DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            push, pop;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign s_input_ready = rst_n & (count_q < CNT_FULL);
    assign push          = s_input_valid & s_input_ready;
    assign pop           = dispatch_en & (count_q != '0);
    assign head          = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{data: s_input, shift: s_shift, mask: s_lane_enable};
    end

    // Root stage: the shift is applied once here so every lane sees the same value.
    logic [31:0]           root_data_d, root_data_q;
    logic [TREE_WIDTH-1:0] root_mask_q;
    logic [TREE_DEPTH:0]   vld_pipe_q;
    logic [31:0]           dispatch_cnt_q;

    assign root_data_d = 32'($signed(head.data) >>> head.shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_data_q <= '0;
            root_mask_q <= '0;
        end else if (pop) begin
            root_data_q <= root_data_d;
            root_mask_q <= head.mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q     <= '0;
            dispatch_cnt_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[TREE_DEPTH-1:0], pop};
            if (vld_pipe_q[TREE_DEPTH]) dispatch_cnt_q <= dispatch_cnt_q + 1'b1;
        end
    end

    // Nodes are heap-indexed; stage k node i owns mask bits [i*MW +: MW] of its stage row,
    // which is exactly the matching half of its parent's slice.
    logic [NODES-1:0][31:0]                node_data;
    logic [TREE_DEPTH:0][TREE_WIDTH-1:0]   node_mask;

    assign node_data[0] = root_data_q;
    assign node_mask[0] = root_mask_q;

    for (genvar k = 1; k <= TREE_DEPTH; k++) begin : g_stage
        localparam int MW = TREE_WIDTH >> k;
        for (genvar i = 0; i < (1 << k); i++) begin : g_node
            sgd_bcast_node #(.MW(MW)) u_node (
                .clk    (clk),
                .rst_n  (rst_n),
                .en_i   (vld_pipe_q[k-1]),
                .data_i (node_data[(1 << (k-1)) - 1 + i/2]),
                .mask_i (node_mask[k-1][i*MW +: MW]),
                .data_o (node_data[(1 << k) - 1 + i]),
                .mask_o (node_mask[k][i*MW +: MW])
            );
        end
    end

    for (genvar l = 0; l < TREE_WIDTH; l++) begin : g_lane
        assign v_output[l]        = node_mask[TREE_DEPTH][l] ? $signed(node_data[LEAF0 + l]) : '0;
        assign v_output_enable[l] = node_mask[TREE_DEPTH][l] & vld_pipe_q[TREE_DEPTH];
    end

    assign v_output_valid = vld_pipe_q[TREE_DEPTH];
    assign dispatch_cnt   = dispatch_cnt_q;
endmodule

// File: tb/tb_sgd_scalar_bcast_tree.sv
// Directed bench for the scalar broadcast tree (depth 3, 8 lanes, 4-entry FIFO).
module tb_sgd_scalar_bcast_tree;
  localparam int W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] s_input = '0;
  logic [4:0]         s_shift = '0;
  logic [W-1:0]       s_lane_enable = '0;
  logic               s_input_valid = 1'b0;
  logic               s_input_ready;
  logic               dispatch_en = 1'b0;
  logic signed [31:0] v_output [W-1:0];
  logic               v_output_enable [W-1:0];
  logic               v_output_valid;
  logic [31:0]        dispatch_cnt;

  int n_chk = 0, n_pass = 0, cyc = 0, exp_cnt = 0;
  int mon_val[$];
  int mon_cyc[$];

  sgd_scalar_bcast_tree #(.TREE_DEPTH(3), .TREE_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_input(s_input), .s_shift(s_shift),
    .s_lane_enable(s_lane_enable), .s_input_valid(s_input_valid),
    .s_input_ready(s_input_ready), .dispatch_en(dispatch_en),
    .v_output(v_output), .v_output_enable(v_output_enable),
    .v_output_valid(v_output_valid), .dispatch_cnt(dispatch_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (v_output_valid) begin
    mon_val.push_back(v_output[0]);
    mon_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] en_vec();
    logic [W-1:0] v;
    for (int l = 0; l < W; l++) v[l] = v_output_enable[l];
    return v;
  endfunction

  task automatic push(input logic [31:0] d, input logic [4:0] sh, input logic [W-1:0] m);
    bit done = 0;
    s_input = d; s_shift = sh; s_lane_enable = m; s_input_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (s_input_ready) done = 1;
      tick();
    end
    s_input_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic run_single(input string tag, input logic [31:0] d, input logic [4:0] sh,
                            input logic [W-1:0] m, input logic [31:0] expv);
    push(d, sh, m);
    repeat (3) tick();
    chk({tag, "_early"}, v_output_valid, 0);
    tick();
    chk({tag, "_valid"}, v_output_valid, 1);
    for (int l = 0; l < W; l++)
      chk($sformatf("%s_lane%0d", tag, l), $unsigned(v_output[l]), m[l] ? expv : 32'h0);
    chk({tag, "_en"}, en_vec(), m);
    tick();
    chk({tag, "_one_cycle"}, v_output_valid, 0);
    exp_cnt++;
    chk({tag, "_cnt"}, dispatch_cnt, exp_cnt);
  endtask

  task automatic chk_stream(input string tag, input int first, input int n);
    chk({tag, "_count"}, mon_val.size(), n);
    for (int j = 0; j < mon_val.size() && j < n; j++) begin
      chk($sformatf("%s_val%0d", tag, j), mon_val[j], first + j * ((tag == "full") ? 11 : 1));
      chk($sformatf("%s_gap%0d", tag, j), mon_cyc[j] - mon_cyc[0], j);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    #2;
    chk("rst_ready", s_input_ready, 0);
    chk("rst_valid", v_output_valid, 0);
    chk("rst_cnt", dispatch_cnt, 0);
    chk("rst_lane0", $unsigned(v_output[0]), 0);
    chk("rst_en", en_vec(), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", s_input_ready, 1);

    dispatch_en = 1'b1;
    run_single("single",  32'h0000_0064, 5'd0,  8'hFF, 32'h0000_0064);
    run_single("shneg",   32'hFFFF_FF00, 5'd4,  8'h0F, 32'hFFFF_FFF0);
    run_single("sh31neg", 32'h8000_0000, 5'd31, 8'hAA, 32'hFFFF_FFFF);
    run_single("sh31pos", 32'h7FFF_FFFF, 5'd31, 8'h55, 32'h0000_0000);
    run_single("sh8",     32'h1234_5678, 5'd8,  8'h81, 32'h0012_3456);
    run_single("mask0",   32'h0000_0007, 5'd0,  8'h00, 32'h0000_0000);

    // full FIFO, held source, then simultaneous push+pop
    mon_val.delete(); mon_cyc.delete();
    dispatch_en = 1'b0;
    push(11, 0, 8'hFF); push(22, 0, 8'hFF); push(33, 0, 8'hFF); push(44, 0, 8'hFF);
    chk("full_ready", s_input_ready, 0);
    s_input = 55; s_shift = 0; s_lane_enable = 8'hFF; s_input_valid = 1'b1;
    repeat (2) tick();
    chk("full_held_ready", s_input_ready, 0);
    chk("full_held_no_out", mon_val.size(), 0);
    dispatch_en = 1'b1;
    tick();
    chk("simul_ready", s_input_ready, 1);
    tick();
    s_input_valid = 1'b0;
    repeat (8) tick();
    chk_stream("full", 11, 5);
    exp_cnt += 5;
    chk("full_cnt", dispatch_cnt, exp_cnt);
    chk("full_ready_after", s_input_ready, 1);

    // streaming
    mon_val.delete(); mon_cyc.delete();
    for (int i = 1; i <= 16; i++) push(i, 0, 8'hFF);
    repeat (8) tick();
    chk_stream("stream", 1, 16);
    exp_cnt += 16;
    chk("stream_cnt", dispatch_cnt, exp_cnt);

    // reset mid-flight: 2 in the tree, 3 queued
    mon_val.delete(); mon_cyc.delete();
    dispatch_en = 1'b0;
    push(101, 0, 8'hFF); push(102, 0, 8'hFF); push(103, 0, 8'hFF); push(104, 0, 8'hFF);
    dispatch_en = 1'b1;
    repeat (2) tick();
    dispatch_en = 1'b0;
    push(105, 0, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", v_output_valid, 0);
    chk("mid_rst_ready", s_input_ready, 0);
    chk("mid_rst_cnt", dispatch_cnt, 0);
    for (int l = 0; l < W; l++) chk($sformatf("mid_rst_lane%0d", l), $unsigned(v_output[l]), 0);
    chk("mid_rst_en", en_vec(), 0);
    tick();
    rst_n = 1'b1;
    dispatch_en = 1'b1;
    repeat (10) tick();
    chk("mid_rst_no_out", mon_val.size(), 0);
    chk("mid_rst_cnt_after", dispatch_cnt, 0);
    chk("mid_rst_ready_after", s_input_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
